// File: rtl/k005297_bootsync_if.sv
// ---------------------------------------------------------------------------
// k005297_bootsync_if
//
// Bundles the qualifier, mode and data inputs of the bootloop sync detector
// together with its status outputs. The master modport belongs to whatever
// feeds the detector (the bubble controller datapath or a bench). The slave
// modport belongs to the detector itself.
//
// Signals:
//   i_CLK2M_PCEN_n       active-low clock enable; state only advances on enabled edges
//   i_BMODE_n            bootloader mode, active low
//   i_BDI                serial bubble data in
//   i_BIT_STB_n          active-low bit-valid qualifier for i_BDI
//   o_SYNCED_FLAG_SET_n  active-low one-enable-period pulse on lock
//   o_PAGE_STB_n         active-low one-enable-period pulse per page while locked
//   o_SYNC_ERR_n         active-low sticky hunt-timeout error
//   o_STATE              debug state code
// ---------------------------------------------------------------------------
interface k005297_bootsync_if;
  logic       i_CLK2M_PCEN_n;
  logic       i_BMODE_n;
  logic       i_BDI;
  logic       i_BIT_STB_n;
  logic       o_SYNCED_FLAG_SET_n;
  logic       o_PAGE_STB_n;
  logic       o_SYNC_ERR_n;
  logic [2:0] o_STATE;

  modport master (
    output i_CLK2M_PCEN_n, i_BMODE_n, i_BDI, i_BIT_STB_n,
    input  o_SYNCED_FLAG_SET_n, o_PAGE_STB_n, o_SYNC_ERR_n, o_STATE
  );

  modport slave (
    input  i_CLK2M_PCEN_n, i_BMODE_n, i_BDI, i_BIT_STB_n,
    output o_SYNCED_FLAG_SET_n, o_PAGE_STB_n, o_SYNC_ERR_n, o_STATE
  );
endinterface

// File: rtl/k005297_bootsync.sv
// ---------------------------------------------------------------------------
// k005297_bootsync
//
// Bootloop sync-pattern detector. While bootloader mode is active it hunts
// the serial data-in stream for SYNC_PATTERN. It then confirms the word on
// CONFIRM_CNT further page-aligned positions. On the confirming bit it
// raises a one-enable-period active-low request that the access-mode flag
// stage uses to switch the address latch source to user. Once locked it
// marks every page start.
//
// Optional feature (compile-time macro K005297_BOOTSYNC_TIMEOUT_EN):
//   defined   - HUNT gives up after TIMEOUT_BITS accepted bits and parks in
//               FAIL with a sticky o_SYNC_ERR_n until mode exit.
//   undefined - no hunt counter and no FAIL state. HUNT runs indefinitely
//               and o_SYNC_ERR_n is tied high.
//
// Ports:
//   i_MCLK       master clock
//   i_SYS_RST_n  asynchronous active-low reset
//   bus          k005297_bootsync_if.slave (enable, mode, data, strobe in;
//                lock pulse, page strobe, error, state code out)
// ---------------------------------------------------------------------------
module k005297_bootsync #(
  parameter logic [15:0] SYNC_PATTERN = 16'hF0E1,
  parameter int unsigned PAGE_BITS    = 160,
  parameter int unsigned CONFIRM_CNT  = 2,
  parameter int unsigned TIMEOUT_BITS = 4096
) (
  input  logic              i_MCLK,
  input  logic              i_SYS_RST_n,
  k005297_bootsync_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HUNT   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } state_e;

  localparam logic [9:0] PAGE_LAST   = 10'(PAGE_BITS - 1);
  localparam logic [2:0] CONF_TARGET = 3'(CONFIRM_CNT);

  state_e      state_q, state_d;
  // The oldest bit of the 16-bit window is never needed after a shift. Only
  // the 15 most recent bits are kept, and the window is {sr_q, i_BDI}.
  logic [14:0] sr_q, sr_d;
  logic [9:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  conf_cnt_q, conf_cnt_d;
  logic        flag_n_q, flag_n_d;
  logic        page_n_q, page_n_d;
`ifdef K005297_BOOTSYNC_TIMEOUT_EN
  localparam logic [12:0] TIMEOUT_LIM = 13'(TIMEOUT_BITS);
  logic [12:0] hunt_cnt_q, hunt_cnt_d, hunt_inc;
  logic        err_n_q, err_n_d;
`endif

  logic        en;
  logic        bit_acc;
  logic        match;
  logic [15:0] window;
  logic [2:0]  conf_inc;

  assign en       = ~bus.i_CLK2M_PCEN_n;
  assign bit_acc  = en & ~bus.i_BIT_STB_n;
  assign window   = {sr_q, bus.i_BDI};
  assign match    = (window == SYNC_PATTERN);
  assign conf_inc = conf_cnt_q + 3'd1;
`ifdef K005297_BOOTSYNC_TIMEOUT_EN
  // Saturating increment: the hunt counter must never wrap back to zero.
  assign hunt_inc = (hunt_cnt_q == '1) ? hunt_cnt_q : hunt_cnt_q + 13'd1;
`endif

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path through the block can infer a latch.
    state_d    = state_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    conf_cnt_d = conf_cnt_q;
    flag_n_d   = flag_n_q;
    page_n_d   = page_n_q;
`ifdef K005297_BOOTSYNC_TIMEOUT_EN
    hunt_cnt_d = hunt_cnt_q;
    err_n_d    = err_n_q;
`endif

    if (en) begin
      // Pulses last exactly one enable period: released on the next enabled
      // edge whether or not a bit is accepted there.
      flag_n_d = 1'b1;
      page_n_d = 1'b1;

      if (bus.i_BMODE_n) begin
        // Mode exit overrides any match or timeout on the same edge.
        state_d    = ST_IDLE;
        sr_d       = '0;
        bit_cnt_d  = '0;
        conf_cnt_d = '0;
`ifdef K005297_BOOTSYNC_TIMEOUT_EN
        hunt_cnt_d = '0;
        err_n_d    = 1'b1;
`endif
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_d    = ST_HUNT;
            bit_cnt_d  = '0;
            conf_cnt_d = '0;
`ifdef K005297_BOOTSYNC_TIMEOUT_EN
            hunt_cnt_d = '0;
`endif
          end

          ST_HUNT: begin
            if (bit_acc) begin
              sr_d = window[14:0];
`ifdef K005297_BOOTSYNC_TIMEOUT_EN
              hunt_cnt_d = hunt_inc;
`endif
              if (match) begin
                state_d    = ST_VERIFY;
                bit_cnt_d  = '0;
                conf_cnt_d = '0;
              end
`ifdef K005297_BOOTSYNC_TIMEOUT_EN
              // A match on the timeout bit is taken first (branch above).
              else if (hunt_inc >= TIMEOUT_LIM) begin
                state_d = ST_FAIL;
                err_n_d = 1'b0;
              end
`endif
            end
          end

          ST_VERIFY: begin
            if (bit_acc) begin
              sr_d = window[14:0];
              if (bit_cnt_q == PAGE_LAST) begin
                bit_cnt_d = '0;
                if (match) begin
                  conf_cnt_d = conf_inc;
                  if (conf_inc == CONF_TARGET) begin
                    state_d  = ST_LOCKED;
                    flag_n_d = 1'b0;
                  end
                end else begin
                  // The shift register is kept, so a new hunt can hit
                  // within fewer than 16 bits.
                  state_d = ST_HUNT;
`ifdef K005297_BOOTSYNC_TIMEOUT_EN
                  hunt_cnt_d = '0;
`endif
                end
              end else begin
                bit_cnt_d = bit_cnt_q + 10'd1;
              end
            end
          end

          ST_LOCKED: begin
            if (bit_acc) begin
              sr_d = window[14:0];
              if (bit_cnt_q == PAGE_LAST) begin
                bit_cnt_d = '0;
                page_n_d  = 1'b0;
              end else begin
                bit_cnt_d = bit_cnt_q + 10'd1;
              end
            end
          end

`ifdef K005297_BOOTSYNC_TIMEOUT_EN
          ST_FAIL: begin
            // Parked until mode exit; the error stays asserted.
          end
`endif

          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the same pre-edge values.
  always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
    if (!i_SYS_RST_n) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      conf_cnt_q <= '0;
      flag_n_q   <= 1'b1;
      page_n_q   <= 1'b1;
`ifdef K005297_BOOTSYNC_TIMEOUT_EN
      hunt_cnt_q <= '0;
      err_n_q    <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      conf_cnt_q <= conf_cnt_d;
      flag_n_q   <= flag_n_d;
      page_n_q   <= page_n_d;
`ifdef K005297_BOOTSYNC_TIMEOUT_EN
      hunt_cnt_q <= hunt_cnt_d;
      err_n_q    <= err_n_d;
`endif
    end
  end

  assign bus.o_STATE             = state_q;
  assign bus.o_SYNCED_FLAG_SET_n = flag_n_q;
  assign bus.o_PAGE_STB_n        = page_n_q;
`ifdef K005297_BOOTSYNC_TIMEOUT_EN
  assign bus.o_SYNC_ERR_n        = err_n_q;
`else
  assign bus.o_SYNC_ERR_n        = 1'b1;
`endif

endmodule

// File: tb/tb_k005297_bootsync.sv
// ---------------------------------------------------------------------------
// tb_k005297_bootsync
//
// Randomised bench for k005297_bootsync. The driver feeds bit streams with
// random enable spacing and optional strobe gaps. It steps a behavioural
// model once per enabled edge. Whenever the model's outputs change, it
// queues the outputs together with the clock cycle they must appear on. A
// monitor compares the DUT against that queue on every cycle where either
// side changes. A few spec-fixed bit indices are also checked directly.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_k005297_bootsync;

  localparam logic [15:0] PAT  = 16'hF0E1;
  localparam int          PAGE = 160;
  localparam int          CONF = 2;
  localparam int          TMO  = 4096;

  logic i_MCLK      = 1'b0;
  logic i_SYS_RST_n = 1'b1;

  k005297_bootsync_if bus ();

  k005297_bootsync #(
    .SYNC_PATTERN(PAT),
    .PAGE_BITS   (PAGE),
    .CONFIRM_CNT (CONF),
    .TIMEOUT_BITS(TMO)
  ) dut (
    .i_MCLK     (i_MCLK),
    .i_SYS_RST_n(i_SYS_RST_n),
    .bus        (bus)
  );

  always #5 i_MCLK = ~i_MCLK;

  int cyc = 0;
  always @(posedge i_MCLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int pack(input int st, input logic f, input logic p, input logic e);
    return (st << 3) | (int'(f) << 2) | (int'(p) << 1) | int'(e);
  endfunction

  function automatic int dut_pack();
    return pack(int'(bus.o_STATE), bus.o_SYNCED_FLAG_SET_n, bus.o_PAGE_STB_n, bus.o_SYNC_ERR_n);
  endfunction

  // ---------------- behavioural model ----------------
  // Bits are numbered per session (from HUNT entry). Page positions are
  // derived from the distance to the first hit and to the lock bit.
  int          m_st;
  logic [15:0] m_hist;
  int          m_n, m_hunt_bits, m_anchor, m_hits, m_lock_at;
  logic        m_flag, m_page, m_err;
  int          m_last;

  typedef struct { int cyc; int outs; } ev_t;
  ev_t exp_q[$];

  task automatic model_reset();
    m_st = 0; m_hist = '0; m_n = 0; m_hunt_bits = 0;
    m_anchor = 0; m_hits = 0; m_lock_at = 0;
    m_flag = 1'b1; m_page = 1'b1; m_err = 1'b1;
  endtask

  task automatic model_edge(input logic bmode_n, input logic acc, input logic bdi);
    m_flag = 1'b1;
    m_page = 1'b1;
    if (bmode_n) begin
      m_st = 0; m_hist = '0; m_err = 1'b1;
      return;
    end
    case (m_st)
      0: begin m_st = 1; m_n = 0; m_hunt_bits = 0; end
      1: if (acc) begin
        m_hist = {m_hist[14:0], bdi};
        m_hunt_bits++;
        if (m_hist == PAT) begin
          m_st = 2; m_anchor = m_n; m_hits = 0;
        end
`ifdef K005297_BOOTSYNC_TIMEOUT_EN
        else if (m_hunt_bits >= TMO) begin
          m_st = 4; m_err = 1'b0;
        end
`endif
        m_n++;
      end
      2: if (acc) begin
        m_hist = {m_hist[14:0], bdi};
        if (m_n - m_anchor == PAGE * (m_hits + 1)) begin
          if (m_hist == PAT) begin
            m_hits++;
            if (m_hits == CONF) begin m_st = 3; m_lock_at = m_n; m_flag = 1'b0; end
          end else begin
            m_st = 1; m_hunt_bits = 0;
          end
        end
        m_n++;
      end
      3: if (acc) begin
        if (m_n > m_lock_at && (m_n - m_lock_at) % PAGE == 0) m_page = 1'b0;
        m_n++;
      end
      default: ;
    endcase
  endtask

  task automatic publish(input int at);
    int  o;
    ev_t e;
    o = pack(m_st, m_flag, m_page, m_err);
    if (o != m_last) begin
      e.cyc = at; e.outs = o;
      exp_q.push_back(e);
      m_last = o;
    end
  endtask

  // ---------------- stimulus ----------------
  bit stim[$];

  task automatic drive_cycle(input logic pcen_n, input logic bmode_n, input logic stb_n, input logic bdi);
    @(negedge i_MCLK);
    bus.i_CLK2M_PCEN_n = pcen_n;
    bus.i_BMODE_n      = bmode_n;
    bus.i_BIT_STB_n    = stb_n;
    bus.i_BDI          = bdi;
    if (!pcen_n) begin
      model_edge(bmode_n, !stb_n, bdi);
      publish(cyc + 1);
    end
  endtask

  task automatic idle_cycles();
    repeat ($urandom_range(1, 0))
      drive_cycle(1'b1, 1'b0, bit'($urandom_range(1, 0)), bit'($urandom_range(1, 0)));
  endtask

  task automatic feed_bit(input logic bdi, input int gap_max);
    int gaps;
    gaps = $urandom_range(gap_max, 0);
    for (int g = 0; g < gaps; g++) begin
      idle_cycles();
      drive_cycle(1'b0, 1'b0, 1'b1, bit'($urandom_range(1, 0)));
    end
    idle_cycles();
    drive_cycle(1'b0, 1'b0, 1'b0, bdi);
  endtask

  task automatic place(input int s, input logic [15:0] w);
    if (s >= 0)
      for (int b = 0; b < 16; b++) stim[s + b] = w[15 - b];
  endtask

  function automatic bit stream_ok(input int s0, input int s1, input int s2, input int s3);
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < stim.size(); i++) begin
      w = {w[14:0], stim[i]};
      if (i >= 15 && w == PAT && !((i - 15) inside {s0, s1, s2, s3})) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Random filler with sync words at s0..s3 (-1 = none) and a one-bit
  // corrupted word at bad; regenerated until no unintended match exists.
  task automatic build_stream(input int len, input int s0, input int s1, input int s2,
                              input int s3, input int bad);
    logic [15:0] p;
    p = PAT;
    do begin
      stim.delete();
      for (int i = 0; i < len; i++) stim.push_back(bit'($urandom_range(1, 0)));
      place(s0, p); place(s1, p); place(s2, p); place(s3, p);
      place(bad, p ^ 16'h0001);
    end while (!stream_ok(s0, s1, s2, s3));
  endtask

  // Enters HUNT, then feeds n_bits. Around bit 'mark' the state code is
  // checked directly; 'poll' > 0 adds periodic still-hunting checks.
  task automatic run_stream(input int gap_max, input int n_bits, input int mark,
                            input int pre_st, input int post_st, input int poll);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < n_bits; i++) begin
      feed_bit(stim[i], gap_max);
      if (i == mark - 1 || i == mark || (poll > 0 && (i % poll) == poll - 1)) begin
        @(posedge i_MCLK); #2;
        if (i == mark - 1) check("state_before_mark", int'(bus.o_STATE), pre_st);
        if (i == mark) begin
          check("state_at_mark", int'(bus.o_STATE), post_st);
          if (post_st == 3) check("lock_pulse_at_mark", int'(bus.o_SYNCED_FLAG_SET_n), 0);
          else              check("err_at_mark", int'(bus.o_SYNC_ERR_n), 0);
        end
        if (poll > 0 && (i % poll) == poll - 1) begin
          check("hunting_state", int'(bus.o_STATE), 1);
          check("hunting_err", int'(bus.o_SYNC_ERR_n), 1);
        end
      end
    end
  endtask

  task automatic exit_mode();
    drive_cycle(1'b0, 1'b1, 1'b0, bit'($urandom_range(1, 0)));
    @(posedge i_MCLK); #2;
    check("exit_state", int'(bus.o_STATE), 0);
    check("exit_err", int'(bus.o_SYNC_ERR_n), 1);
    check("exit_flag", int'(bus.o_SYNCED_FLAG_SET_n), 1);
    repeat (2) drive_cycle(1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic pulse_reset();
    @(negedge i_MCLK);
    bus.i_CLK2M_PCEN_n = 1'b1;
    i_SYS_RST_n = 1'b0;
    model_reset();
    publish(cyc + 1);
    #1;
    check("rst_state", int'(bus.o_STATE), 0);
    check("rst_flag", int'(bus.o_SYNCED_FLAG_SET_n), 1);
    check("rst_page", int'(bus.o_PAGE_STB_n), 1);
    check("rst_err", int'(bus.o_SYNC_ERR_n), 1);
    @(negedge i_MCLK);
    i_SYS_RST_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    int   exp_cur, prev, cur;
    bit   due;
    ev_t  e;
    exp_cur = pack(0, 1'b1, 1'b1, 1'b1);
    prev    = exp_cur;
    forever begin
      @(posedge i_MCLK); #1;
      cur = dut_pack();
      due = 1'b0;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        exp_cur = e.outs;
        due = 1'b1;
      end
      if (due || cur != prev) check("outputs{state,flag,page,err}", cur, exp_cur);
      prev = cur;
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main
    bus.i_CLK2M_PCEN_n = 1'b1;
    bus.i_BMODE_n      = 1'b1;
    bus.i_BIT_STB_n    = 1'b1;
    bus.i_BDI          = 1'b0;
    model_reset();
    m_last = pack(0, 1'b1, 1'b1, 1'b1);
    #2 i_SYS_RST_n = 1'b0;
    repeat (3) @(negedge i_MCLK);
    check("reset_state", int'(bus.o_STATE), 0);
    check("reset_flag", int'(bus.o_SYNCED_FLAG_SET_n), 1);
    check("reset_page", int'(bus.o_PAGE_STB_n), 1);
    check("reset_err", int'(bus.o_SYNC_ERR_n), 1);
    i_SYS_RST_n = 1'b1;

    // Clean lock, then asynchronous reset while locked.
    build_stream(900, 40, 200, 360, -1, -1);
    run_stream(0, 900, 375, 2, 3, 0);
    pulse_reset();

    // False first hit, corrupted second page, real lock later.
    build_stream(800, 10, 300, 460, 620, 170);
    run_stream(0, 800, 635, 2, 3, 0);
    exit_mode();

    // Clean-lock data with random strobe gaps.
    build_stream(700, 40, 200, 360, -1, -1);
    run_stream(5, 700, 375, 2, 3, 0);
    exit_mode();

    // Mode exit during VERIFY.
    build_stream(120, 40, -1, -1, -1, -1);
    run_stream(0, 100, -1, 0, 0, 0);
    @(posedge i_MCLK); #2;
    check("abort_in_verify", int'(bus.o_STATE), 2);
    exit_mode();

`ifdef K005297_BOOTSYNC_TIMEOUT_EN
    build_stream(4200, -1, -1, -1, -1, -1);
    run_stream(0, 4200, 4095, 1, 4, 0);
    @(posedge i_MCLK); #2;
    check("fail_held_state", int'(bus.o_STATE), 4);
    check("fail_held_err", int'(bus.o_SYNC_ERR_n), 0);
    exit_mode();
`else
    build_stream(10000, -1, -1, -1, -1, -1);
    run_stream(0, 10000, -1, 0, 0, 1000);
    exit_mode();
`endif

    repeat (4) @(negedge i_MCLK);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
